ldm_stm_sequencer: RTL

Multi-register transfer sequencer for LDM/STM block transfers. It sits directly beside the register file. For loads it drives the write port (write_reg/write_data/regwrite) with one register per memory beat. For stores it drives read port 1 (read_reg_num1) and forwards read_data1 to memory. It also handles address generation for the four ARM addressing modes and optional base-register writeback.

---
 rtl/ldm_stm_sequencer_pkg.sv | 24 ++
 rtl/ldm_stm_sequencer_reg_list_encoder.sv | 24 ++
 rtl/ldm_stm_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer:
// addressing-mode codes, FSM state encoding and word size.
package ldm_stm_sequencer_pkg;

  localparam logic [1:0] MODE_IA = 2'd0;  // increment after
  localparam logic [1:0] MODE_IB = 2'd1;  // increment before
  localparam logic [1:0] MODE_DA = 2'd2;  // decrement after
  localparam logic [1:0] MODE_DB = 2'd3;  // decrement before

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One-hot mask for a register index, used to retire a transferred register.
  function automatic logic [15:0] reg_mask(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_reg_list_encoder.sv
// Register-list encoder: lowest set index, non-empty flag and popcount of a
// 16-bit LDM/STM register list. Purely combinational.
module reg_list_encoder (
  input  logic [15:0] list,
  output logic [3:0]  lowest,
  output logic        valid,
  output logic [4:0]  count
);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    lowest = '0;
    count  = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) begin
        lowest = 4'(i);
      end
      count = count + {4'b0000, list[i]};
    end
    valid = |list;
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM multi-register transfer sequencer. Sits beside the register file:
// loads drive the write port one register per memory beat, stores drive read
// port 1 and forward its data to memory. Handles IA/IB/DA/DB address
// generation and optional base-register writeback.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic [15:0]           reg_list,
  input  logic [1:0]            addr_mode,
  input  logic [DATA_W-1:0]     base_addr,
  input  logic [3:0]            base_reg,
  input  logic                  wb_en,
  output logic [REG_ADDR_W-1:0] read_reg_num1,
  input  logic [DATA_W-1:0]     read_data1,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     write_data,
  output logic                  regwrite,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done
);

  state_t            state_q;
  logic [15:0]       pending_q;
  logic [15:0]       list_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] final_q;
  logic              is_load_q;
  logic [3:0]        base_reg_q;
  logic              wb_en_q;

  // The encoder looks at the incoming list while idle (for N) and at the
  // pending list during the transfer (for the current register).
  logic [15:0] enc_in;
  logic [3:0]  enc_lowest;
  logic        enc_valid;
  logic [4:0]  enc_count;

  assign enc_in = (state_q == ST_IDLE) ? reg_list : pending_q;

  reg_list_encoder u_encoder (
    .list   (enc_in),
    .lowest (enc_lowest),
    .valid  (enc_valid),
    .count  (enc_count)
  );

  logic [DATA_W-1:0]     step;
  logic [DATA_W-1:0]     span;
  logic [DATA_W-1:0]     start_addr;
  logic [DATA_W-1:0]     final_base;
  logic [15:0]           pending_next;
  logic                  last_beat;
  logic [REG_ADDR_W-1:0] cur_reg;
  logic                  wb_suppress;

  assign step         = DATA_W'(WORD_BYTES);
  assign span         = DATA_W'(enc_count) * step;
  assign pending_next = pending_q & ~reg_mask(enc_lowest);
  assign last_beat    = (enc_count == 5'd1);
  assign cur_reg      = REG_ADDR_W'(enc_lowest);
  // A load that includes the base register keeps the loaded value.
  assign wb_suppress  = is_load_q && list_q[base_reg_q];

  // First beat address and written-back base for the four addressing modes.
  always_comb begin
    start_addr = base_addr;
    final_base = base_addr + span;
    case (addr_mode)
      MODE_IA: start_addr = base_addr;
      MODE_IB: start_addr = base_addr + step;
      MODE_DA: start_addr = base_addr - span + step;
      MODE_DB: start_addr = base_addr - span;
      default: start_addr = base_addr;
    endcase
    if (addr_mode == MODE_DA || addr_mode == MODE_DB) begin
      final_base = base_addr - span;
    end
  end

  // Sequencer FSM: latch the request, walk the list one beat per ack,
  // optional writeback, one-cycle done.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      list_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      is_load_q  <= 1'b0;
      base_reg_q <= '0;
      wb_en_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            is_load_q  <= is_load;
            list_q     <= reg_list;
            pending_q  <= reg_list;
            base_reg_q <= base_reg;
            wb_en_q    <= wb_en;
            addr_q     <= start_addr;
            final_q    <= final_base;
            state_q    <= enc_valid ? ST_XFER : ST_DONE;
          end
        end
        ST_XFER: begin
          if (mem_ack) begin
            pending_q <= pending_next;
            addr_q    <= addr_q + step;
            if (last_beat) begin
              state_q <= wb_en_q ? ST_WB : ST_DONE;
            end
          end
        end
        ST_WB:   state_q <= ST_DONE;
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output decode from the registered state; everything is 0 while idle.
  // Register writes are gated by reset so an abort performs no further write.
  always_comb begin
    read_reg_num1 = '0;
    write_reg     = '0;
    write_data    = '0;
    regwrite      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    case (state_q)
      ST_XFER: begin
        mem_req  = 1'b1;
        mem_we   = ~is_load_q;
        mem_addr = addr_q;
        if (!is_load_q) begin
          read_reg_num1 = cur_reg;
          mem_wdata     = read_data1;
        end else if (mem_ack && !reset) begin
          regwrite   = 1'b1;
          write_reg  = cur_reg;
          write_data = mem_rdata;
        end
      end
      ST_WB: begin
        if (!reset && !wb_suppress) begin
          regwrite   = 1'b1;
          write_reg  = REG_ADDR_W'(base_reg_q);
          write_data = final_q;
        end
      end
      default: ;
    endcase
  end

endmodule
